// File: rtl/sm_stim_driver.sv
// Stimulus driver / response collector for the (i1,i2 -> o1,o2,err) FSM family.
// Plays a loadable table of {hold,i2,i1} steps and tallies err cycles and fired outputs.
module sm_stim_driver #(
    parameter int DEPTH  = 16,
    parameter int AW     = 4,
    parameter int HOLD_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [HOLD_W+1:0] wr_data,
    input  logic [AW-1:0]     len,
    input  logic              start,
    input  logic              o1,
    input  logic              o2,
    input  logic              err,
    output logic              i1,
    output logic              i2,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  err_cnt,
    output logic [1:0]        o_seen
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t            r_state;
    logic [HOLD_W+1:0] r_table [DEPTH];
    logic [AW-1:0]     r_idx;
    logic [AW-1:0]     r_last;
    logic [HOLD_W-1:0] r_hold;

    logic [HOLD_W+1:0] w_entry0;
    logic [AW-1:0]     w_idx_nxt;
    logic [HOLD_W+1:0] w_entry_nxt;
    logic              w_wr_ok;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != {CNT_W{1'b1}}))
            return v + {{(CNT_W-1){1'b0}}, 1'b1};
        return v;
    endfunction

    assign w_wr_ok     = wr_en && (r_state == S_IDLE);
    // A write to entry 0 in the start cycle must be what the first step plays.
    assign w_entry0    = (w_wr_ok && (wr_addr == '0)) ? wr_data : r_table[0];
    assign w_idx_nxt   = r_idx + {{(AW-1){1'b0}}, 1'b1};
    assign w_entry_nxt = r_table[w_idx_nxt];

    // Table storage is deliberately unreset so a run can be replayed after an abort.
    always_ff @(posedge clk) begin
        if (w_wr_ok)
            r_table[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_last  <= '0;
            r_hold  <= '0;
            i1      <= 1'b1;
            i2      <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err_cnt <= '0;
            o_seen  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    i1   <= 1'b1;
                    i2   <= 1'b0;
                    done <= 1'b0;
                    if (start) begin
                        r_state             <= S_RUN;
                        busy                <= 1'b1;
                        r_idx               <= '0;
                        r_last              <= len;
                        {r_hold, i2, i1}    <= w_entry0;
                        err_cnt             <= '0;
                        o_seen              <= '0;
                    end
                end
                S_RUN: begin
                    err_cnt <= sat_inc(err_cnt, err);
                    o_seen  <= o_seen | {o2, o1};
                    if (r_hold != '0) begin
                        r_hold <= r_hold - {{(HOLD_W-1){1'b0}}, 1'b1};
                    end else if (r_idx != r_last) begin
                        r_idx            <= w_idx_nxt;
                        {r_hold, i2, i1} <= w_entry_nxt;
                    end else begin
                        r_state <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        i1      <= 1'b1;
                        i2      <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    done    <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    i1      <= 1'b1;
                    i2      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sm_stim_driver.sv
// Scoreboard bench for sm_stim_driver: the stimulus side expands the table model into an
// expected per-cycle code stream and end-of-run results; a negedge monitor checks the DUT.
module tb_sm_stim_driver;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_addr = '0;
    logic [5:0] wr_data = '0;
    logic [3:0] len = '0;
    logic       start = 1'b0;
    logic       o1 = 1'b0, o2 = 1'b0, err = 1'b0;
    logic       i1, i2, busy, done;
    logic [7:0] err_cnt;
    logic [1:0] o_seen;

    sm_stim_driver #(.DEPTH(16), .AW(4), .HOLD_W(4), .CNT_W(8)) dut (
        .clk(clk), .nrst(nrst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .len(len), .start(start), .o1(o1), .o2(o2), .err(err),
        .i1(i1), .i2(i2), .busy(busy), .done(done), .err_cnt(err_cnt), .o_seen(o_seen)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int done_seen = 0;
    int runs_exp = 0;

    logic [5:0] mdl [16];
    logic [1:0] exp_q [$];
    logic [9:0] res_q [$];
    logic [9:0] hold_res = '0;
    logic       prev_done = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: pops expected codes while busy, end-of-run results on done.
    always @(negedge clk) begin
        if (!nrst) begin
            hold_res  = '0;
            prev_done = 1'b0;
        end else begin
            if (busy) begin
                check("done_in_run", {31'd0, done}, 32'd0);
                if (exp_q.size() == 0) begin
                    check("run_too_long", 32'd1, 32'd0);
                end else begin
                    logic [1:0] e;
                    e = exp_q.pop_front();
                    check("code", {30'd0, i2, i1}, {30'd0, e});
                end
            end else begin
                check("idle_code", {30'd0, i2, i1}, 32'd1);
                if (done) begin
                    done_seen++;
                    check("done_width", {31'd0, prev_done}, 32'd0);
                    check("run_too_short", exp_q.size(), 32'd0);
                    if (res_q.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        hold_res = res_q.pop_front();
                        check("err_cnt", {24'd0, err_cnt}, {24'd0, hold_res[9:2]});
                        check("o_seen", {30'd0, o_seen}, {30'd0, hold_res[1:0]});
                    end
                end else begin
                    check("hold_results", {22'd0, err_cnt, o_seen}, {22'd0, hold_res});
                end
            end
            prev_done = done;
        end
    end

    task automatic wr(input logic [3:0] a, input logic [5:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        mdl[a] = d;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    // mode 0 random err/o, 1 err=1 + single o1 pulse, 2 err=1 only, 3 quiet
    task automatic do_run(input logic [3:0] ln, input int mode, input int abort_at,
                          input bit guard, input bit wr_with_start, input logic [5:0] wd);
        int L, cnt;
        logic [1:0] os;
        if (wr_with_start) begin
            wr_en = 1'b1; wr_addr = 4'd0; wr_data = wd;
            mdl[0] = wd;
        end
        L = 0;
        for (int s = 0; s <= int'(ln); s++)
            for (int r = 0; r <= int'(mdl[s][5:2]); r++) begin
                exp_q.push_back(mdl[s][1:0]);
                L++;
            end
        len = ln; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; wr_en = 1'b0;
        cnt = 0; os = 2'b00;
        for (int k = 0; k < L; k++) begin
            if (k == abort_at) begin
                nrst = 1'b0;
                exp_q.delete();
                #1;
                check("abort_code", {30'd0, i2, i1}, 32'd1);
                check("abort_busy", {31'd0, busy}, 32'd0);
                check("abort_err_cnt", {24'd0, err_cnt}, 32'd0);
                check("abort_o_seen", {30'd0, o_seen}, 32'd0);
                err = 1'b0; o1 = 1'b0; o2 = 1'b0;
                @(posedge clk); @(posedge clk); #1;
                nrst = 1'b1;
                return;
            end
            case (mode)
                0: begin err = 1'($urandom); o1 = ($urandom_range(0, 7) == 0); o2 = ($urandom_range(0, 7) == 0); end
                1: begin err = 1'b1; o1 = (k == 1); o2 = 1'b0; end
                2: begin err = 1'b1; o1 = 1'b0; o2 = 1'b0; end
                default: begin err = 1'b0; o1 = 1'b0; o2 = 1'b0; end
            endcase
            cnt += int'(err);
            os |= {o2, o1};
            if (guard && (k == 1)) begin
                wr_en = 1'b1; wr_addr = 4'd0; wr_data = ~mdl[0]; start = 1'b1;
            end else begin
                wr_en = 1'b0; start = 1'b0;
            end
            @(posedge clk); #1;
        end
        err = 1'b0; o1 = 1'b0; o2 = 1'b0; wr_en = 1'b0; start = 1'b0;
        res_q.push_back({(cnt > 255) ? 8'd255 : 8'(cnt), os});
        runs_exp++;
        @(posedge clk); #1;
    endtask

    task automatic load_t2();
        wr(4'd0, 6'b000011);
        wr(4'd1, 6'b001010);
        wr(4'd2, 6'b000000);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_code", {30'd0, i2, i1}, 32'd1);
        check("rst_busy_done", {30'd0, busy, done}, 32'd0);
        check("rst_err_cnt", {24'd0, err_cnt}, 32'd0);
        check("rst_o_seen", {30'd0, o_seen}, 32'd0);
        nrst = 1'b1;
        @(posedge clk); #1;

        for (int a = 0; a < 16; a++) wr(4'(a), 6'($urandom));
        load_t2();
        do_run(4'd2, 3, -1, 1'b0, 1'b0, '0);
        do_run(4'd2, 1, -1, 1'b0, 1'b0, '0);
        do_run(4'd2, 0, 2, 1'b0, 1'b0, '0);
        do_run(4'd2, 0, -1, 1'b0, 1'b0, '0);
        do_run(4'd2, 0, -1, 1'b1, 1'b0, '0);
        do_run(4'd2, 2, -1, 1'b0, 1'b0, '0);
        do_run(4'd2, 0, -1, 1'b0, 1'b1, 6'b000110);

        for (int n = 0; n < 6; n++) begin
            for (int a = 0; a < 16; a++) wr(4'(a), 6'($urandom));
            do_run(4'($urandom), 0, -1, 1'b0, 1'b0, '0);
        end

        for (int a = 0; a < 16; a++) wr(4'(a), {4'hF, 2'($urandom)});
        do_run(4'd15, 2, -1, 1'b0, 1'b0, '0);

        repeat (3) @(posedge clk);
        #1;
        check("leftover_codes", exp_q.size(), 32'd0);
        check("leftover_results", res_q.size(), 32'd0);
        check("done_count", done_seen, runs_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
